// File: rtl/arcade_input_mapper_pkg.sv
// Shared constants and types for the arcade keyboard/joystick button mapper.
package arcade_input_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_FIRE  = 4;
    localparam int BTN_BOMB  = 5;
    localparam int BTN_START = 6;
    localparam int BTN_COIN  = 7;

    localparam logic [8:0] SCAN_UNMAPPED = 9'h000;

    // Default PS/2 set-2 scancodes, bit 8 = E0-extended.
    localparam logic [8:0] SC_UP    = 9'h175;
    localparam logic [8:0] SC_DOWN  = 9'h172;
    localparam logic [8:0] SC_LEFT  = 9'h16B;
    localparam logic [8:0] SC_RIGHT = 9'h174;
    localparam logic [8:0] SC_CTRL  = 9'h014;
    localparam logic [8:0] SC_SPACE = 9'h029;
    localparam logic [8:0] SC_KEY5  = 9'h02E;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_e;

    typedef struct packed {
        logic       pressed;
        logic [8:0] code;
    } key_event_t;

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Scancode-table configuration bus: one write strobe, entry index and scancode.
interface arcade_input_mapper_if #(
    parameter int ADDR_W = 4
);
    logic              cfg_wr;
    logic [ADDR_W-1:0] cfg_addr;
    logic [8:0]        cfg_data;

    modport master (output cfg_wr, cfg_addr, cfg_data);
    modport slave  (input  cfg_wr, cfg_addr, cfg_data);
endinterface

// File: rtl/arcade_input_mapper_pulse_shaper.sv
// Coin pulse shaper: a rising edge of level_i yields one PULSE_LEN-cycle pulse.
module arcade_pulse_shaper #(
    parameter int PULSE_LEN = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);
    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_i;
            // Edges arriving while the pulse is running are ignored.
            if (cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
            else if (level_i && !level_q)
                cnt_q <= CNT_W'(PULSE_LEN);
        end
    end

    assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Maps the ps2_key toggle stream through a loadable scancode table, merges joystick
// bits, applies autofire and coin shaping, and registers the cabinet button vector.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int PLAYERS      = 2,
    parameter int BUTTONS      = 8,
    parameter int COIN_IDX     = BTN_COIN,
    parameter int COIN_PULSE   = 16,
    parameter int AUTOFIRE_DIV = 200000,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                         clk_sys,
    input  logic                         RESET,
    input  logic [10:0]                  ps2_key,
    input  logic [PLAYERS*BUTTONS-1:0]   joy_in,
    arcade_input_mapper_if.slave         cfg,
    input  logic [BUTTONS-1:0]           autofire_en,
    input  logic                         kbd_clear,
    output logic [PLAYERS*BUTTONS-1:0]   btn_out,
    output logic                         busy,
    output logic                         overflow
);
    localparam int N     = PLAYERS * BUTTONS;
    localparam int IDX_W = $clog2(N);
    localparam int AF_W  = $clog2(AUTOFIRE_DIV);
    localparam logic [N-1:0] INV_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [8:0]       table_q [N];
    logic [N-1:0]     key_state_q, key_state_d;
    logic             armed_q, old_toggle_q;
    scan_state_e      state_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q, overflow_q;
    key_event_t       cur_q, pend_q;
    logic             pend_valid_q;
    logic [AF_W-1:0]  af_cnt_q;
    logic             af_phase_q;
    logic [N-1:0]     btn_out_q;

    logic             ev;
    key_event_t       ev_data;
    logic             scan_last;
    logic [N-1:0]     merged, shaped;
    logic [PLAYERS-1:0] coin_pulse;

    assign ev        = armed_q && (ps2_key[10] != old_toggle_q);
    assign ev_data   = '{pressed: ps2_key[9], code: ps2_key[8:0]};
    assign scan_last = (idx_q == IDX_W'(N - 1));

    // NOTE: the table is a handful of flops, so it is reset like any other state.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) table_q[i] <= SCAN_UNMAPPED;
        end else if (cfg.cfg_wr) begin
            table_q[cfg.cfg_addr] <= cfg.cfg_data;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        key_state_d = key_state_q;
        if (state_q == SCAN && cur_q.code != SCAN_UNMAPPED && table_q[idx_q] == cur_q.code)
            key_state_d[idx_q] = cur_q.pressed;
        // A rewritten entry starts released so a remap can never leave a stuck key.
        if (cfg.cfg_wr)
            key_state_d[cfg.cfg_addr] = 1'b0;
        if (kbd_clear)
            key_state_d = '0;
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            armed_q      <= 1'b0;
            old_toggle_q <= 1'b0;
            key_state_q  <= '0;
            state_q      <= IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            cur_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            armed_q      <= 1'b1;
            old_toggle_q <= ps2_key[10];
            key_state_q  <= key_state_d;
            if (kbd_clear) begin
                state_q      <= IDLE;
                idx_q        <= '0;
                busy_q       <= 1'b0;
                overflow_q   <= 1'b0;
                pend_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ev) begin
                            cur_q   <= ev_data;
                            idx_q   <= '0;
                            state_q <= SCAN;
                            busy_q  <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (scan_last) begin
                            idx_q <= '0;
                            // Pending is consumed first; a same-cycle event refills it.
                            if (pend_valid_q) begin
                                cur_q        <= pend_q;
                                pend_valid_q <= ev;
                                if (ev) pend_q <= ev_data;
                            end else if (ev) begin
                                cur_q <= ev_data;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            if (ev) begin
                                if (pend_valid_q) begin
                                    overflow_q <= 1'b1;
                                end else begin
                                    pend_q       <= ev_data;
                                    pend_valid_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign merged = key_state_q | joy_in;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        arcade_pulse_shaper #(
            .PULSE_LEN (COIN_PULSE)
        ) u_coin (
            .clk_i   (clk_sys),
            .rst_i   (RESET),
            .level_i (merged[p*BUTTONS + COIN_IDX]),
            .pulse_o (coin_pulse[p])
        );
    end

    always_comb begin
        shaped = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int b = 0; b < BUTTONS; b++) begin
                if (b == COIN_IDX)
                    shaped[p*BUTTONS + b] = coin_pulse[p];
                else if (autofire_en[b])
                    shaped[p*BUTTONS + b] = merged[p*BUTTONS + b] & af_phase_q;
                else
                    shaped[p*BUTTONS + b] = merged[p*BUTTONS + b];
            end
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
            btn_out_q  <= INV_MASK;
        end else begin
            if (af_cnt_q == AF_W'(AUTOFIRE_DIV - 1)) begin
                af_cnt_q   <= '0;
                af_phase_q <= ~af_phase_q;
            end else begin
                af_cnt_q <= af_cnt_q + AF_W'(1);
            end
            btn_out_q <= shaped ^ INV_MASK;
        end
    end

    assign btn_out  = btn_out_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
